// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_pkg
// Purpose  : Shared traffic-light types and default constants.
// Revision : 1.0
// ============================================================================
package tl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } tl_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_STUCK_CYCLES    = 1000;
    localparam int WAIT_MAX                = 15;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'(WAIT_MAX)) ? v : v + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce
// Purpose  : Two-flop synchronizer followed by a consecutive-sample debouncer.
// Revision : 1.0
// ============================================================================
module sync_debounce
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [7:0] c_last = 8'(DEBOUNCE_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic [7:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_count <= 8'd0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            // Any agreeing sample restarts the run of disagreements.
            if (r_sync2 == r_level) begin
                r_count <= 8'd0;
            end else if (r_count == c_last) begin
                r_level <= r_sync2;
                r_count <= 8'd0;
            end else begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign dout = r_level;

endmodule
`default_nettype wire

// File: rtl/vehicle_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : vehicle_sensor_conditioner
// Purpose  : Loop-detector conditioning, service-request FSM, stuck detection.
// Revision : 1.0
// ============================================================================
module vehicle_sensor_conditioner
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int STUCK_CYCLES    = DEFAULT_STUCK_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loop_raw,
    input  logic       sg_in,
    output logic       sensor,
    output logic       presence,
    output logic [3:0] waiting,
    output logic       fault
);

    localparam logic [15:0] c_stuck_limit = 16'(STUCK_CYCLES);

    logic       w_presence;
    logic       r_presence_d;
    logic       w_arrival;
    tl_state_e  r_state;
    tl_state_e  w_next_state;
    logic [3:0] r_waiting;
    logic [3:0] w_waiting_next;
    logic       r_sensor;
    logic [15:0] r_stuck_cnt;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (loop_raw),
        .dout  (w_presence)
    );

    assign w_arrival = w_presence & ~r_presence_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_sensor     <= 1'b0;
            r_waiting    <= 4'd0;
            r_presence_d <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_sensor     <= (w_next_state == REQUEST);
            r_waiting    <= w_waiting_next;
            r_presence_d <= w_presence;
        end
    end

    // A clear that coincides with an arrival leaves that arrival counted.
    always_comb begin
        w_next_state   = r_state;
        w_waiting_next = w_arrival ? sat_inc4(r_waiting) : r_waiting;
        case (r_state)
            IDLE: begin
                if (sg_in) begin
                    w_waiting_next = {3'b000, w_arrival};
                end
                if (w_arrival) begin
                    w_next_state = REQUEST;
                end
            end
            REQUEST: begin
                if (sg_in) begin
                    w_next_state   = SERVICE;
                    w_waiting_next = {3'b000, w_arrival};
                end
            end
            SERVICE: begin
                if (!sg_in) begin
                    w_next_state = ((r_waiting != 4'd0) || w_presence) ? REQUEST : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stuck_cnt <= 16'd0;
        end else if (!w_presence) begin
            r_stuck_cnt <= 16'd0;
        end else if (r_stuck_cnt != c_stuck_limit) begin
            r_stuck_cnt <= r_stuck_cnt + 16'd1;
        end
    end

    assign sensor   = r_sensor;
    assign presence = w_presence;
    assign waiting  = r_waiting;
    assign fault    = (r_stuck_cnt == c_stuck_limit);

endmodule
`default_nettype wire

// File: tb/tb_vehicle_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_vehicle_sensor_conditioner
// Purpose  : Scoreboard bench with a behavioural model of the conditioner.
// Revision : 1.0
// ============================================================================
module tb_vehicle_sensor_conditioner;

    localparam int DEB = 4;
    localparam int STK = 50;

    typedef struct packed {
        logic       sensor;
        logic       presence;
        logic [3:0] waiting;
        logic       fault;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       loop_raw;
    logic       sg_in;
    logic       sensor;
    logic       presence;
    logic [3:0] waiting;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    // Model state: values as they stand after the most recent edge.
    int m_s1, m_s2, m_pres, m_prev, m_state, m_wait, m_stuck;
    int hist[$];

    vehicle_sensor_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .STUCK_CYCLES    (STK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .loop_raw (loop_raw),
        .sg_in    (sg_in),
        .sensor   (sensor),
        .presence (presence),
        .waiting  (waiting),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_pres = 0; m_prev = 0;
        m_state = 0; m_wait = 0; m_stuck = 0;
        hist.delete();
    endtask

    // Predicts outputs after the coming edge from the current inputs.
    task automatic model_step(input int raw, input int sg);
        int arrival, run, n_pres, n_state, n_wait, n_stuck;
        exp_t e;
        if (reset !== 1'b1) begin
            model_reset();
            exp_q.push_back('0);
            return;
        end
        arrival = (m_pres == 1 && m_prev == 0);
        hist.push_back(m_s2);
        if (hist.size() > 300) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] != m_pres; i--) run++;
        n_pres  = (run >= DEB) ? 1 - m_pres : m_pres;
        n_stuck = m_pres ? ((m_stuck + 1 > STK) ? STK : m_stuck + 1) : 0;
        n_state = m_state;
        if (m_state == 0 && arrival) n_state = 1;
        else if (m_state == 1 && sg) n_state = 2;
        else if (m_state == 2 && !sg) n_state = (m_wait > 0 || m_pres) ? 1 : 0;
        if (sg && m_state != 2) n_wait = arrival;
        else if (arrival) n_wait = (m_wait >= 15) ? 15 : m_wait + 1;
        else n_wait = m_wait;
        m_prev = m_pres; m_pres = n_pres; m_s2 = m_s1; m_s1 = raw;
        m_state = n_state; m_wait = n_wait; m_stuck = n_stuck;
        e.sensor   = (n_state == 1);
        e.presence = n_pres[0];
        e.waiting  = 4'(n_wait);
        e.fault    = (n_stuck == STK);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit raw, input bit sg);
        loop_raw = raw;
        sg_in    = sg;
        model_step(int'(raw), int'(sg));
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        model_reset();
        #1;
        chk("reset_immediate", int'({sensor, presence, waiting, fault}), 0);
        for (int i = 0; i < n; i++) step(loop_raw, sg_in);
        reset = 1'b1;
    endtask

    task automatic arrivals(input int n);
        for (int a = 0; a < n; a++) begin
            for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
            for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        end
    endtask

    // Monitor: compares every registered output set against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                if ({sensor, presence, waiting, fault} !== mon_e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t: got s=%b p=%b w=%0d f=%b expected s=%b p=%b w=%0d f=%b",
                             $time, sensor, presence, waiting, fault,
                             mon_e.sensor, mon_e.presence, mon_e.waiting, mon_e.fault);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int raw_left, sg_left;
        bit raw_v, sg_v;
        int k;
        reset = 1'b0; loop_raw = 1'b1; sg_in = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        chk("reset_outputs", int'({sensor, presence, waiting, fault}), 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        reset = 1'b1;

        // Loop already high at release: debounced, then counted as an arrival.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("presence_edge5", presence, 0);
        step(1'b1, 1'b0);
        chk("presence_edge6", presence, 1);
        chk("sensor_edge6", sensor, 0);
        step(1'b1, 1'b0);
        chk("sensor_edge7", sensor, 1);
        chk("waiting_edge7", waiting, 1);

        // Handshake.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("service_sensor", sensor, 0);
        chk("service_waiting", waiting, 0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("idle_sensor", sensor, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("idle_stays", sensor, 0);

        // Bounce then hold high.
        for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("bounce_presence5", presence, 0);
        step(1'b1, 1'b0);
        chk("bounce_presence6", presence, 1);
        step(1'b1, 1'b0);
        chk("bounce_sensor", sensor, 1);
        chk("bounce_waiting", waiting, 1);

        // Arrival while in service.
        step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        chk("svc_arrival_waiting", waiting, 1);
        chk("svc_arrival_sensor", sensor, 0);
        step(1'b0, 1'b0);
        chk("svc_exit_request", sensor, 1);

        // Saturation, then arrival coinciding with service entry.
        arrivals(20);
        chk("waiting_saturated", waiting, 15);
        k = 0;
        while (!(m_pres == 1 && m_prev == 0) && k < 20) begin
            step(1'b1, 1'b0);
            k++;
        end
        chk("arrival_pending", int'(m_pres == 1 && m_prev == 0), 1);
        step(1'b1, 1'b1);
        chk("coincident_waiting", waiting, 1);
        chk("coincident_sensor", sensor, 0);

        // Stuck detection: presence rose one edge before the coincident step.
        for (int i = 0; i < 48; i++) step(1'b1, 1'b0);
        chk("fault_before_limit", fault, 0);
        step(1'b1, 1'b0);
        chk("fault_at_limit", fault, 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("fault_holds", fault, 1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        chk("presence_fell", presence, 0);
        chk("fault_still_set", fault, 1);
        step(1'b0, 1'b0);
        chk("fault_cleared", fault, 0);

        // Reset mid-request.
        apply_reset(2);
        arrivals(3);
        chk("pre_reset_waiting", waiting, 3);
        chk("pre_reset_sensor", sensor, 1);
        apply_reset(2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk("post_reset_idle", sensor, 0);
        chk("post_reset_waiting", waiting, 0);

        // Randomized traffic.
        raw_left = 0; sg_left = 0; raw_v = 1'b0; sg_v = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (raw_left == 0) begin
                raw_v    = 1'($urandom_range(0, 1));
                raw_left = int'($urandom_range(1, 10));
            end
            if (sg_left == 0) begin
                sg_v    = ($urandom_range(0, 2) == 0);
                sg_left = int'($urandom_range(1, 25));
            end
            if ($urandom_range(0, 599) == 0) apply_reset(2);
            step(raw_v, sg_v);
            raw_left--;
            sg_left--;
        end

        step(1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vehicle_sensor_conditioner.md
VEHICLE_SENSOR_CONDITIONER -- requirements
Module: vehicle_sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive disagreeing cycles before the debounced level flips (range 1..255).
REQ-002 Parameter STUCK_CYCLES, default 1000: continuous debounced presence before a fault is flagged (range 2..65535).
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port loop_raw, input, 1: raw side-street loop detector; asynchronous to clk; may bounce.
REQ-006 Port sg_in, input, 1: side-street green from the downstream light controller; synchronous to clk.
REQ-007 Port sensor, output, 1: service request to the downstream light controller.
REQ-008 Port presence, output, 1: debounced loop level.
REQ-009 Port waiting, output, 4: saturating count of vehicle arrivals not yet serviced.
REQ-010 Port fault, output, 1: loop stuck-high indication.

Function
REQ-011 loop_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 presence SHALL flip only after the synchronized input differs from presence for DEBOUNCE_CYCLES consecutive edges; any agreeing cycle SHALL clear the debounce counter.
REQ-013 With DEBOUNCE_CYCLES=4, loop_raw held high before edge 1 SHALL give presence=1 after edge 6 and sensor=1 after edge 7.
REQ-014 An arrival SHALL be a 0->1 transition of presence, producing a one-cycle internal pulse; 1->0 transitions SHALL NOT count.
REQ-015 The state machine SHALL have three states: IDLE, REQUEST and SERVICE.
REQ-016 IDLE: sensor=0; an arrival SHALL cause a transition to REQUEST on the next edge.
REQ-017 REQUEST: sensor=1; sg_in=1 SHALL cause a transition to SERVICE on the next edge.
REQ-018 SERVICE: sensor=0; sg_in=0 SHALL cause a transition to REQUEST if waiting>0 or presence=1, and to IDLE otherwise.
REQ-019 sensor SHALL be a registered function of state only: 1 in REQUEST, 0 in IDLE and SERVICE.
REQ-020 waiting SHALL increment on every arrival in any state and saturate at 15.
REQ-021 waiting SHALL clear on the REQUEST->SERVICE transition; an arrival on that same edge SHALL leave waiting=1.
REQ-022 sg_in=1 while in IDLE (controller cycling on its own timer) SHALL clear waiting and SHALL NOT change state.
REQ-023 A 16-bit stuck counter SHALL count cycles with presence=1 and clear when presence=0.
REQ-024 fault SHALL assert when the stuck counter reaches STUCK_CYCLES; the counter SHALL then hold.
REQ-025 fault SHALL remain set until presence returns to 0, then clear on the following edge.
REQ-026 fault SHALL NOT gate sensor; it is status only.

Reset
REQ-027 With reset=0 (asserted), all outputs SHALL be 0: sensor, presence, waiting, fault.
REQ-028 While reset is asserted, the state SHALL be IDLE and the synchronizer, debounce counter and stuck counter SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge, and SHALL discard any pending request.
REQ-030 After reset deassertion, a loop already high SHALL be treated as a new arrival once debounced.

Structure
REQ-031 The state enum (IDLE/REQUEST/SERVICE) and the default constants SHALL live in shared package tl_pkg, also used by the light controller.
REQ-032 The synchronizer and debouncer SHALL be one sub-module, sync_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, din, dout).
REQ-033 The FSM, waiting counter and stuck detector SHALL reside in the top module.

Verification
REQ-034 Bounce: loop_raw toggling every 2 cycles for 20 cycles, then held high -> presence=1 exactly 6 edges after the final rise, waiting=1, sensor=1 one edge later.
REQ-035 Handshake: from REQUEST, sg_in=1 for 10 cycles then 0 with loop low -> SERVICE on the edge after sg_in rises, waiting=0, IDLE on the edge after sg_in falls.
REQ-036 Arrival during service: a debounced arrival while in SERVICE -> waiting=1, REQUEST (sensor=1) on the edge after sg_in falls.
REQ-037 Saturation: 20 clean arrivals with no sg_in -> waiting=15 and held; a simultaneous arrival and service entry -> waiting=1.
REQ-038 Stuck loop: STUCK_CYCLES=50, loop held high -> fault=1 when the stuck count reaches 50; loop low, once debounced -> fault=0 one edge after presence falls.
REQ-039 Reset: reset driven 0 between edges while in REQUEST with waiting=3 -> sensor=0 and waiting=0 immediately, state IDLE after release.
